recovery_fetch_router: RTL and testbench

//  Routes the core instruction-fetch port to one of two targets: recovery_code_rom or main instr memory.

---
 rtl/recovery_fetch_router.sv | 117 +++++++++++
 tb/tb_recovery_fetch_router.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/recovery_fetch_router.sv
// Steers core instruction fetches to the recovery ROM window or main memory, one fetch outstanding.
// Latency: ROM 1 cycle (1 word/cycle back-to-back); memory as granted/returned by mem_*; no timeout.
module recovery_fetch_router #(
    parameter logic [31:0] ROM_BASE = 32'h0004_0080,
    parameter logic [31:0] ROM_SIZE = 32'h0000_0100,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             core_req_i,
    input  logic [31:0]      core_addr_i,
    output logic             core_gnt_o,
    output logic             core_rvalid_o,
    output logic [31:0]      core_rdata_o,
    output logic             rom_req_o,
    output logic [31:0]      rom_addr_o,
    input  logic [31:0]      rom_rdata_i,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [CNT_W-1:0] rom_fetch_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROM_RSP = 2'd1,
        MEM_RSP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] addr_off;
    logic        in_win;
    logic        can_accept;
    logic        rom_grant;
    logic        mem_try;
    logic        mem_grant;

    // Subtract-then-compare keeps the decode correct even if the window touches 2^32.
    assign addr_off   = core_addr_i - ROM_BASE;
    assign in_win     = (core_addr_i >= ROM_BASE) && (addr_off < ROM_SIZE);
    assign can_accept = (state_q != MEM_RSP);
    assign rom_grant  = can_accept && core_req_i && in_win;
    assign mem_try    = can_accept && core_req_i && !in_win;
    assign mem_grant  = mem_try && mem_gnt_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_RSP: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (rom_grant) begin
                    state_d = ROM_RSP;
                end else if (mem_grant) begin
                    state_d = MEM_RSP;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rom_grant && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is forced low while reset is asserted, including the pass-through addresses.
    always_comb begin
        core_gnt_o      = 1'b0;
        core_rvalid_o   = 1'b0;
        core_rdata_o    = 32'd0;
        rom_req_o       = 1'b0;
        rom_addr_o      = 32'd0;
        mem_req_o       = 1'b0;
        mem_addr_o      = 32'd0;
        rom_fetch_cnt_o = '0;
        busy_o          = 1'b0;
        if (!rst_i) begin
            rom_addr_o      = {core_addr_i[31:2], 2'b00};
            mem_addr_o      = core_addr_i;
            rom_fetch_cnt_o = cnt_q;
            busy_o          = (state_q != IDLE);
            rom_req_o       = rom_grant;
            mem_req_o       = mem_try;
            core_gnt_o      = rom_grant || mem_grant;
            if (state_q == ROM_RSP) begin
                core_rvalid_o = 1'b1;
                core_rdata_o  = rom_rdata_i;
            end else if ((state_q == MEM_RSP) && mem_rvalid_i) begin
                core_rvalid_o = 1'b1;
                core_rdata_o  = mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_recovery_fetch_router.sv
// Bench for recovery_fetch_router: directed scenarios then random traffic against a queue-based model.
module tb_recovery_fetch_router;

    localparam logic [31:0] BASE = 32'h0004_0080;
    localparam logic [31:0] SIZE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_i, core_req_i, mem_gnt_i, mem_rvalid_i;
    logic [31:0] core_addr_i, rom_rdata_i, mem_rdata_i;
    logic        core_gnt_o, core_rvalid_o, rom_req_o, mem_req_o, busy_o;
    logic [31:0] core_rdata_o, rom_addr_o, mem_addr_o;
    logic [15:0] rom_fetch_cnt_o;

    logic        s_gnt, s_rvalid, s_romreq, s_memreq, s_busy;
    logic [31:0] s_rdata, s_romaddr, s_memaddr;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    recovery_fetch_router #(.ROM_BASE(BASE), .ROM_SIZE(SIZE), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .core_req_i(core_req_i), .core_addr_i(core_addr_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rom_fetch_cnt_o(rom_fetch_cnt_o), .busy_o(busy_o)
    );

    recovery_fetch_router #(.ROM_BASE(BASE), .ROM_SIZE(SIZE), .CNT_W(2)) dut_small (
        .clk_i(clk), .rst_i(rst_i), .core_req_i(core_req_i), .core_addr_i(core_addr_i),
        .core_gnt_o(s_gnt), .core_rvalid_o(s_rvalid), .core_rdata_o(s_rdata),
        .rom_req_o(s_romreq), .rom_addr_o(s_romaddr), .rom_rdata_i(rom_rdata_i),
        .mem_req_o(s_memreq), .mem_addr_o(s_memaddr), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rom_fetch_cnt_o(s_cnt), .busy_o(s_busy)
    );

    typedef struct {
        bit          is_rom;
        logic [31:0] addr;
    } fetch_t;

    fetch_t outq[$];
    int     grants = 0;
    int     n_pass = 0;
    int     n_total = 0;

    function automatic logic [31:0] romword(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1234};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic rq, input logic [31:0] a,
                        input logic g, input logic rv, input logic [31:0] md);
        logic        e_gnt, e_rv, e_romreq, e_memreq, e_busy, smp_req;
        logic [31:0] e_rd, e_ra, e_ma, smp_addr;
        longint      al;
        bit          win, has, blocked;
        fetch_t      head;
        int          e_cnt, e_small;

        rst_i = r; core_req_i = rq; core_addr_i = a;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = md;
        #1;
        al  = longint'(a);
        win = (al >= longint'(BASE)) && (al < longint'(BASE) + longint'(SIZE));
        has = (outq.size() > 0);
        if (has) head = outq[0];
        blocked = has && !head.is_rom;
        e_gnt = 0; e_rv = 0; e_romreq = 0; e_memreq = 0; e_busy = 0;
        e_rd = 0; e_ra = 0; e_ma = 0; e_cnt = 0; e_small = 0;
        if (!r) begin
            e_ra    = {a[31:2], 2'b00};
            e_ma    = a;
            e_busy  = has;
            e_cnt   = (grants > 65535) ? 65535 : grants;
            e_small = (grants > 3) ? 3 : grants;
            if (has && head.is_rom) begin
                e_rv = 1; e_rd = romword(head.addr);
            end else if (has && rv) begin
                e_rv = 1; e_rd = md;
            end
            if (rq && !blocked) begin
                if (win) begin
                    e_romreq = 1; e_gnt = 1;
                end else begin
                    e_memreq = 1; e_gnt = g;
                end
            end
        end
        chk("core_gnt", 32'(core_gnt_o), 32'(e_gnt));
        chk("core_rvalid", 32'(core_rvalid_o), 32'(e_rv));
        chk("core_rdata", core_rdata_o, e_rd);
        chk("rom_req", 32'(rom_req_o), 32'(e_romreq));
        chk("rom_addr", rom_addr_o, e_ra);
        chk("mem_req", 32'(mem_req_o), 32'(e_memreq));
        chk("mem_addr", mem_addr_o, e_ma);
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("rom_cnt", 32'(rom_fetch_cnt_o), 32'(e_cnt));
        chk("rom_cnt_sat2", 32'(s_cnt), 32'(e_small));
        smp_req  = rom_req_o;
        smp_addr = rom_addr_o;
        @(posedge clk);
        #1;
        if (r) begin
            outq.delete();
            grants = 0;
        end else begin
            if (has && (head.is_rom || rv)) void'(outq.pop_front());
            if (e_gnt) begin
                outq.push_back('{is_rom: win, addr: {a[31:2], 2'b00}});
                if (win) grants++;
            end
        end
        // The recovery ROM registers its read: data for this cycle's request appears next cycle.
        if (smp_req) rom_rdata_i = romword(smp_addr);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [6];
        edges[0] = BASE - 4; edges[1] = BASE; edges[2] = BASE + SIZE - 4;
        edges[3] = BASE + SIZE - 1; edges[4] = BASE + SIZE; edges[5] = BASE - 1;
        case ($urandom_range(0, 3))
            0:       return BASE + ($urandom % SIZE);
            1:       return edges[$urandom_range(0, 5)];
            2:       return $urandom;
            default: return BASE - 32'h40 + $urandom_range(0, 32'h200);
        endcase
    endfunction

    initial begin
        rom_rdata_i = 32'd0;
        // Reset held with a pending request
        repeat (3) step(1, 1, BASE, 1, 1, 32'hDEAD_BEEF);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        // Single ROM fetch, then a 4-word burst
        step(0, 1, 32'h0004_0080, 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h0004_0080 + 32'(4 * i), 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        // Window edges
        step(0, 1, 32'h0004_007C, 1, 0, 32'd0);
        step(0, 0, 32'd0, 0, 1, 32'h1111_0001);
        step(0, 1, 32'h0004_017C, 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        step(0, 1, 32'h0004_0180, 1, 0, 32'd0);
        step(0, 0, 32'd0, 0, 1, 32'h2222_0002);
        // Delayed memory grant and response
        step(0, 1, 32'h0000_1000, 0, 0, 32'd0);
        step(0, 1, 32'h0000_1000, 0, 0, 32'd0);
        step(0, 1, 32'h0000_1000, 1, 0, 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 1, 32'h3333_0003);
        // ROM fetch followed by a memory fetch accepted during the ROM response
        step(0, 1, 32'h0004_0090, 0, 0, 32'd0);
        step(0, 1, 32'h0000_2000, 1, 0, 32'd0);
        step(0, 1, 32'h0004_0084, 1, 0, 32'd0);
        step(0, 1, 32'h0004_0084, 1, 1, 32'h4444_0004);
        step(0, 1, 32'h0004_0084, 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        // Stray response, then reset in the middle of a memory fetch
        step(0, 0, 32'd0, 0, 1, 32'h5555_0005);
        step(0, 1, 32'h0000_3000, 1, 0, 32'd0);
        step(1, 0, 32'd0, 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 1, 32'h6666_0006);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        // Five ROM fetches to push the 2-bit counter into saturation
        for (int i = 0; i < 5; i++) step(0, 1, BASE + 32'(8 * i), 0, 0, 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 rand_addr(),
                 ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                 $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
